// File: rtl/pkg_in_arb_pkg.sv
// Shared definitions for the multi-channel packet input arbiter.
package pkg_in_arb_pkg;

  localparam int unsigned ID_W = 3;

  typedef enum logic [1:0] {
    ST_ARB   = 2'b00,
    ST_XFER  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int unsigned n);
    if (32'(v) + 32'd1 >= n) return '0;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/pkg_in_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_pick
  import pkg_in_arb_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic            vld_o,
  output logic [ID_W-1:0] idx_o
);

  always_comb begin
    int unsigned c;
    logic [ID_W-1:0] ci;
    vld_o = 1'b0;
    idx_o = '0;
    c     = 0;
    ci    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr_i) + i;
      if (c >= N) c = c - N;
      ci = c[ID_W-1:0];
      if (!vld_o && req_i[ci]) begin
        vld_o = 1'b1;
        idx_o = ci;
      end
    end
  end

endmodule

// File: rtl/pkg_in_arb.sv
// QoS-first round-robin packet arbiter; forwards one granted channel as a registered
// gapless byte stream, aborting stalled, truncated or oversized packets.
module pkg_in_arb
  import pkg_in_arb_pkg::*;
#(
  parameter int unsigned CH_NUM  = 8,
  parameter int unsigned MAX_LEN = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     ch_valid,
  input  logic [8*CH_NUM-1:0]   ch_data,
  input  logic [CH_NUM-1:0]     ch_sop,
  input  logic [CH_NUM-1:0]     ch_eop,
  input  logic [CH_NUM-1:0]     ch_qos,
  output logic [CH_NUM-1:0]     ch_ready,
  output logic [7:0]            chx_data_out,
  output logic                  chx_sop_out,
  output logic                  chx_eop_out,
  output logic                  chx_qos_out,
  output logic [ID_W-1:0]       chx_id_out,
  output logic                  drop_pulse
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] gnt_q, gnt_d, rr_h_q, rr_h_d, rr_l_q, rr_l_d;
  logic [6:0]      len_q, len_d;
  logic            pqos_q, pqos_d;
  logic [7:0]      data_q;
  logic            sop_q, eop_q, qos_q, drop_q;
  logic [ID_W-1:0] id_q;

  logic [CH_NUM-1:0] cand, cand_h, cand_l;
  logic              hit_h, hit_l, fwd, abort, drop_d;
  logic [ID_W-1:0]   idx_h, idx_l;
  logic              g_valid, g_sop, g_eop;
  logic [7:0]        g_data;

  assign cand   = ch_valid & ch_sop & ~ch_eop;
  assign cand_h = cand & ch_qos;
  assign cand_l = cand & ~ch_qos;

  rr_pick #(.N(CH_NUM)) u_pick_h (.req_i(cand_h), .ptr_i(rr_h_q), .vld_o(hit_h), .idx_o(idx_h));
  rr_pick #(.N(CH_NUM)) u_pick_l (.req_i(cand_l), .ptr_i(rr_l_q), .vld_o(hit_l), .idx_o(idx_l));

  assign g_valid = ch_valid[gnt_q];
  assign g_sop   = ch_sop[gnt_q];
  assign g_eop   = ch_eop[gnt_q];
  assign g_data  = ch_data[8*gnt_q +: 8];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_h_d   = rr_h_q;
    rr_l_d   = rr_l_q;
    len_d    = len_q;
    pqos_d   = pqos_q;
    ch_ready = '0;
    fwd      = 1'b0;
    abort    = 1'b0;
    drop_d   = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        // Headless bytes and single-byte packets are flushed; neither is ever a candidate.
        ch_ready = ch_valid & (~ch_sop | ch_eop);
        drop_d   = |(ch_valid & ch_sop & ch_eop);
        len_d    = '0;
        if (hit_h) begin
          gnt_d   = idx_h;
          pqos_d  = 1'b1;
          rr_h_d  = wrap_inc(idx_h, CH_NUM);
          state_d = ST_XFER;
        end else if (hit_l) begin
          gnt_d   = idx_l;
          pqos_d  = 1'b0;
          rr_l_d  = wrap_inc(idx_l, CH_NUM);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // len is zero until the sop byte has gone out, so it doubles as the "started" flag.
        if (len_q == '0) begin
          ch_ready[gnt_q] = 1'b1;
          if (g_valid) begin
            fwd   = 1'b1;
            len_d = len_q + 7'd1;
            if (g_eop) state_d = ST_ARB;
          end
        end else if (!g_valid) begin
          abort   = 1'b1;
          state_d = ST_DRAIN;
        end else if (g_sop) begin
          abort   = 1'b1;
          state_d = ST_ARB;
        end else begin
          ch_ready[gnt_q] = 1'b1;
          if (g_eop) begin
            fwd     = 1'b1;
            len_d   = len_q + 7'd1;
            state_d = ST_ARB;
          end else if (len_q == 7'(MAX_LEN)) begin
            abort   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            fwd   = 1'b1;
            len_d = len_q + 7'd1;
          end
        end
        drop_d = abort;
      end
      ST_DRAIN: begin
        if (g_valid && g_sop) begin
          state_d = ST_ARB;
        end else begin
          ch_ready[gnt_q] = 1'b1;
          if (g_valid && g_eop) state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
    if (!rst_n) ch_ready = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      gnt_q   <= '0;
      rr_h_q  <= '0;
      rr_l_q  <= '0;
      len_q   <= '0;
      pqos_q  <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      qos_q   <= 1'b0;
      id_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_h_q  <= rr_h_d;
      rr_l_q  <= rr_l_d;
      len_q   <= len_d;
      pqos_q  <= pqos_d;
      drop_q  <= drop_d;
      if (fwd) begin
        data_q <= g_data;
        sop_q  <= g_sop;
        eop_q  <= g_eop;
        qos_q  <= pqos_q;
        id_q   <= gnt_q;
      end else if (abort) begin
        data_q <= '0;
        sop_q  <= 1'b1;
        eop_q  <= 1'b1;
        qos_q  <= pqos_q;
        id_q   <= gnt_q;
      end else begin
        data_q <= '0;
        sop_q  <= 1'b0;
        eop_q  <= 1'b0;
      end
    end
  end

  assign chx_data_out = data_q;
  assign chx_sop_out  = sop_q;
  assign chx_eop_out  = eop_q;
  assign chx_qos_out  = qos_q;
  assign chx_id_out   = id_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_pkg_in_arb.sv
// Directed bench for pkg_in_arb: per-channel byte queues feed the DUT, a cycle trace
// and a packet monitor record the output stream for hand-computed expectations.
module tb_pkg_in_arb;
  localparam int CH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [CH-1:0]   ch_valid, ch_sop, ch_eop, ch_qos, ch_ready;
  logic [8*CH-1:0] ch_data;
  logic [7:0]      chx_data_out;
  logic            chx_sop_out, chx_eop_out, chx_qos_out, drop_pulse;
  logic [2:0]      chx_id_out;

  pkg_in_arb #(.CH_NUM(8), .MAX_LEN(127)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data), .ch_sop(ch_sop),
    .ch_eop(ch_eop), .ch_qos(ch_qos), .ch_ready(ch_ready), .chx_data_out(chx_data_out),
    .chx_sop_out(chx_sop_out), .chx_eop_out(chx_eop_out), .chx_qos_out(chx_qos_out),
    .chx_id_out(chx_id_out), .drop_pulse(drop_pulse)
  );

  typedef struct { logic [7:0] d; logic sop, eop, qos, gap; } beat_t;
  // sop, eop, qos, id, data, drop
  typedef struct packed { logic sop, eop, qos; logic [2:0] id; logic [7:0] d; logic drop; } out_t;

  beat_t chq[CH][$];
  out_t  tr[$];
  int    p_id[$], p_len[$];
  bit    p_qos[$], p_ok[$];
  int    n_drop, n_acc[CH];
  bit    in_pkt;
  int    cur_len, cur_id;
  bit    cur_qos;
  int    checks = 0, errors = 0;

  task automatic clear_mon();
    tr.delete(); p_id.delete(); p_len.delete(); p_qos.delete(); p_ok.delete();
    n_drop = 0; in_pkt = 0; cur_len = 0; cur_id = 0; cur_qos = 0;
    for (int c = 0; c < CH; c++) n_acc[c] = 0;
  endtask

  task automatic drive_heads();
    for (int c = 0; c < CH; c++) begin
      if (chq[c].size() > 0 && !chq[c][0].gap) begin
        ch_valid[c] = 1'b1; ch_sop[c] = chq[c][0].sop; ch_eop[c] = chq[c][0].eop;
        ch_qos[c] = chq[c][0].qos; ch_data[8*c +: 8] = chq[c][0].d;
      end else begin
        ch_valid[c] = 1'b0; ch_sop[c] = 1'b0; ch_eop[c] = 1'b0;
        ch_qos[c] = 1'b0; ch_data[8*c +: 8] = 8'h00;
      end
    end
  endtask

  task automatic load_pkt(input int c, input int len, input bit q, input int base,
                          input int gap_at, input int gap_n);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_n; g++) begin
          b.d = 8'h00; b.sop = 1'b0; b.eop = 1'b0; b.qos = q; b.gap = 1'b1;
          chq[c].push_back(b);
        end
      end
      b.d = 8'((base + i) % 255 + 1); b.sop = (i == 0); b.eop = (i == len - 1);
      b.qos = q; b.gap = 1'b0;
      chq[c].push_back(b);
    end
  endtask

  task automatic tick();
    logic [CH-1:0] acc;
    out_t o;
    #1;
    acc = ch_valid & ch_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      if (chq[c].size() > 0 && (chq[c][0].gap || acc[c])) begin
        if (acc[c]) n_acc[c]++;
        void'(chq[c].pop_front());
      end
    end
    o = {chx_sop_out, chx_eop_out, chx_qos_out, chx_id_out, chx_data_out, drop_pulse};
    tr.push_back(o);
    if (drop_pulse) n_drop++;
    if (chx_sop_out && chx_eop_out) begin
      p_id.push_back(int'(chx_id_out)); p_qos.push_back(chx_qos_out);
      p_len.push_back(cur_len); p_ok.push_back(1'b0); in_pkt = 0;
    end else if (chx_sop_out) begin
      in_pkt = 1; cur_len = 1; cur_id = int'(chx_id_out); cur_qos = chx_qos_out;
    end else if (in_pkt) begin
      cur_len++;
      if (chx_eop_out) begin
        p_id.push_back(cur_id); p_qos.push_back(cur_qos);
        p_len.push_back(cur_len); p_ok.push_back(1'b1); in_pkt = 0;
      end
    end
    drive_heads();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic string ids_str();
    string s = "";
    foreach (p_id[i]) s = {s, $sformatf("%0d ", p_id[i])};
    return s;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int c = 0; c < CH; c++) chq[c].delete();
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic test_reset();
    beat_t b;
    rst_n = 1'b0;
    b.d = 8'h11; b.sop = 1'b0; b.eop = 1'b0; b.qos = 1'b0; b.gap = 1'b0;
    chq[1].push_back(b);
    drive_heads();
    #3;
    checks++;
    if ({chx_sop_out, chx_eop_out, chx_qos_out, chx_id_out, chx_data_out, drop_pulse} !== 15'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0",
        {chx_sop_out, chx_eop_out, chx_qos_out, chx_id_out, chx_data_out, drop_pulse});
    end
    checks++;
    if (ch_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %b want 0", ch_ready); end
    apply_reset();
  endtask

  task automatic test_single_low();
    apply_reset();
    load_pkt(3, 5, 1'b0, 8'h30, -1, 0);
    drive_heads();
    ticks(10);
    checks++;
    if (tr[0] !== 15'h0) begin errors++; $display("FAIL single_bubble got %h want 0", tr[0]); end
    checks++;
    if (tr[1] !== {1'b1, 1'b0, 1'b0, 3'd3, 8'h31, 1'b0}) begin
      errors++; $display("FAIL single_sop got %h want %h", tr[1], {1'b1, 1'b0, 1'b0, 3'd3, 8'h31, 1'b0});
    end
    checks++;
    if (tr[5] !== {1'b0, 1'b1, 1'b0, 3'd3, 8'h35, 1'b0}) begin
      errors++; $display("FAIL single_eop got %h want %h", tr[5], {1'b0, 1'b1, 1'b0, 3'd3, 8'h35, 1'b0});
    end
    checks++;
    if (tr[6] !== {1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0}) begin
      errors++; $display("FAIL single_idle_hold got %h want %h", tr[6], {1'b0, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0});
    end
    checks++;
    if (n_drop !== 0 || p_len.size() != 1 || p_len[0] != 5) begin
      errors++; $display("FAIL single_pkt got drops=%0d pkts=%0d want drops=0 pkts=1 len=5", n_drop, p_len.size());
    end
  endtask

  task automatic test_priority();
    apply_reset();
    load_pkt(1, 3, 1'b0, 8'h10, -1, 0);
    load_pkt(6, 3, 1'b1, 8'h60, -1, 0);
    drive_heads();
    ticks(12);
    checks++;
    if (p_id.size() != 2 || p_id[0] != 6 || p_id[1] != 1 || p_qos[0] != 1'b1 || p_qos[1] != 1'b0) begin
      errors++; $display("FAIL prio_order got ids %s want 6 1 (qos 1 0)", ids_str());
    end
    clear_mon();
    load_pkt(0, 2, 1'b1, 8'h00, -1, 0);
    load_pkt(7, 2, 1'b1, 8'h70, -1, 0);
    drive_heads();
    ticks(10);
    checks++;
    if (p_id.size() != 2 || p_id[0] != 7 || p_id[1] != 0) begin
      errors++; $display("FAIL prio_rr_h got ids %s want 7 0", ids_str());
    end
    clear_mon();
    load_pkt(0, 2, 1'b0, 8'h00, -1, 0);
    load_pkt(3, 2, 1'b0, 8'h30, -1, 0);
    drive_heads();
    ticks(10);
    checks++;
    if (p_id.size() != 2 || p_id[0] != 3 || p_id[1] != 0) begin
      errors++; $display("FAIL prio_rr_l got ids %s want 3 0", ids_str());
    end
  endtask

  task automatic test_back_to_back();
    int viol;
    apply_reset();
    load_pkt(0, 3, 1'b0, 8'h00, -1, 0);
    load_pkt(0, 3, 1'b0, 8'h08, -1, 0);
    load_pkt(2, 3, 1'b0, 8'h20, -1, 0);
    load_pkt(5, 3, 1'b0, 8'h50, -1, 0);
    drive_heads();
    ticks(24);
    checks++;
    if (p_id.size() != 4 || p_id[0] != 0 || p_id[1] != 2 || p_id[2] != 5 || p_id[3] != 0) begin
      errors++; $display("FAIL rr_order got ids %s want 0 2 5 0", ids_str());
    end
    viol = 0;
    for (int k = 0; k + 1 < tr.size(); k++)
      if (tr[k].eop && !tr[k].sop && tr[k+1].sop) viol++;
    checks++;
    if (viol != 0) begin errors++; $display("FAIL rr_bubble got %0d eop->sop adjacencies want 0", viol); end
  endtask

  task automatic test_stall_abort();
    apply_reset();
    load_pkt(4, 8, 1'b0, 8'h40, 3, 2);
    load_pkt(4, 3, 1'b0, 8'h60, -1, 0);
    drive_heads();
    ticks(18);
    checks++;
    if (tr[3] !== {1'b0, 1'b0, 1'b0, 3'd4, 8'h43, 1'b0}) begin
      errors++; $display("FAIL stall_last_byte got %h want %h", tr[3], {1'b0, 1'b0, 1'b0, 3'd4, 8'h43, 1'b0});
    end
    checks++;
    if (tr[4] !== {1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b1}) begin
      errors++; $display("FAIL stall_marker got %h want %h", tr[4], {1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b1});
    end
    checks++;
    if (tr[5].drop !== 1'b0 || n_drop != 1) begin
      errors++; $display("FAIL stall_drop_pulse got next=%b total=%0d want 0 and 1", tr[5].drop, n_drop);
    end
    checks++;
    if (tr[12] !== {1'b1, 1'b0, 1'b0, 3'd4, 8'h61, 1'b0}) begin
      errors++; $display("FAIL stall_next_pkt got %h want %h", tr[12], {1'b1, 1'b0, 1'b0, 3'd4, 8'h61, 1'b0});
    end
    checks++;
    if (chq[4].size() != 0 || n_acc[4] != 11 || p_ok.size() != 2 || p_ok[0] || !p_ok[1]) begin
      errors++; $display("FAIL stall_drain got left=%0d acc=%0d pkts=%0d want 0 11 2", chq[4].size(), n_acc[4], p_ok.size());
    end
  endtask

  task automatic test_flush();
    beat_t b;
    apply_reset();
    b.d = 8'h55; b.sop = 1'b1; b.eop = 1'b1; b.qos = 1'b0; b.gap = 1'b0;
    chq[5].push_back(b);
    b.d = 8'h22; b.sop = 1'b0; b.eop = 1'b0;
    chq[2].push_back(b);
    drive_heads();
    #1;
    checks++;
    if (ch_ready !== 8'b0010_0100) begin errors++; $display("FAIL flush_ready got %b want 00100100", ch_ready); end
    ticks(3);
    checks++;
    if (chq[5].size() != 0 || chq[2].size() != 0 || tr[0].drop !== 1'b1 || tr[1].drop !== 1'b0 || tr[0].sop !== 1'b0) begin
      errors++; $display("FAIL flush_discard got left5=%0d left2=%0d drop=%b%b want 0 0 10",
        chq[5].size(), chq[2].size(), tr[0].drop, tr[1].drop);
    end
  endtask

  task automatic test_oversize();
    apply_reset();
    load_pkt(2, 200, 1'b0, 0, -1, 0);
    drive_heads();
    ticks(210);
    checks++;
    if (tr[127] !== {1'b0, 1'b0, 1'b0, 3'd2, 8'd127, 1'b0}) begin
      errors++; $display("FAIL over_last_byte got %h want %h", tr[127], {1'b0, 1'b0, 1'b0, 3'd2, 8'd127, 1'b0});
    end
    checks++;
    if (tr[128] !== {1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1}) begin
      errors++; $display("FAIL over_marker got %h want %h", tr[128], {1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1});
    end
    checks++;
    if (p_len.size() != 1 || p_len[0] != 127 || p_ok[0] || n_drop != 1 || n_acc[2] != 200 || chq[2].size() != 0) begin
      errors++; $display("FAIL over_drain got pkts=%0d len=%0d drops=%0d acc=%0d want 1 127 1 200",
        p_len.size(), (p_len.size() > 0) ? p_len[0] : -1, n_drop, n_acc[2]);
    end
    clear_mon();
    load_pkt(2, 127, 1'b1, 8'h10, -1, 0);
    drive_heads();
    ticks(135);
    checks++;
    if (p_len.size() != 1 || p_len[0] != 127 || !p_ok[0] || !p_qos[0] || n_drop != 0) begin
      errors++; $display("FAIL over_exact_max got pkts=%0d drops=%0d want one clean 127-byte packet, 0 drops",
        p_len.size(), n_drop);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_pkt(5, 10, 1'b1, 8'h50, -1, 0);
    drive_heads();
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({chx_sop_out, chx_eop_out, chx_qos_out, chx_id_out, chx_data_out, drop_pulse} !== 15'h0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0",
        {chx_sop_out, chx_eop_out, chx_qos_out, chx_id_out, chx_data_out, drop_pulse});
    end
    checks++;
    if (ch_ready !== 8'h00) begin errors++; $display("FAIL midreset_ready got %b want 0", ch_ready); end
    for (int c = 0; c < CH; c++) chq[c].delete();
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    load_pkt(3, 2, 1'b1, 8'h30, -1, 0);
    load_pkt(6, 2, 1'b1, 8'h60, -1, 0);
    drive_heads();
    ticks(10);
    checks++;
    if (p_id.size() != 2 || p_id[0] != 3 || p_id[1] != 6) begin
      errors++; $display("FAIL midreset_rr_restart got ids %s want 3 6", ids_str());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ch_valid = '0; ch_sop = '0; ch_eop = '0; ch_qos = '0; ch_data = '0;
    clear_mon();
    test_reset();
    test_single_low();
    test_priority();
    test_back_to_back();
    test_stall_abort();
    test_flush();
    test_oversize();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
